mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

MEM/WB pipeline stage of the MIPS datapath, directly upstream of the register file. It captures memory-stage results and selects load data or ALU result. It drives the register file write port (`WB`, `writeReg`, `writeData`). The register file reads synchronously, so a read issued on the same edge as a write returns the stale value; this stage provides a one-entry write-through bypass, time-aligned with `RegData1`/`RegData2`, to cover that case.

## Interface
Parameters:
- `DATA_W`, 32, datapath width
- `REG_AW`, 5, register address width

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `stall`  in  1  hold stage contents, insert write bubble
- `flush`  in  1  kill stage contents; priority over `stall`
- `in_valid`  in  1  MEM stage holds a real instruction
- `in_reg_write`  in  1  instruction writes a register
- `in_mem_to_reg`  in  1  1 = load data, 0 = ALU result
- `in_write_reg`  in  REG_AW  destination register
- `in_alu_result`  in  DATA_W  ALU result / load address
- `in_mem_data`  in  DATA_W  raw data-memory word
- `in_load_size`  in  2  00 word, 01 byte, 10 half, 11 reserved (treated as word)
- `in_load_unsigned`  in  1  zero-extend sub-word loads
- `readReg1`, `readReg2`  in  REG_AW  addresses presented to the register file this cycle
- `WB`  out  1  register file write enable
- `writeReg`  out  REG_AW  write address
- `writeData`  out  DATA_W  write data
- `fwd1_sel`, `fwd2_sel`  out  1  use `fwdN_data` instead of `RegDataN`
- `fwd1_data`, `fwd2_data`  out  DATA_W  bypass data

## Operation
- Stage register, on each rising edge:
  - `flush`=1: `WB`←0; other fields don't-care.
  - Else `stall`=1: `WB`←0; `writeReg`/`writeData` hold.
  - Else: `WB` ← `in_valid & in_reg_write & (in_write_reg != 0)`; `writeReg` ← `in_write_reg`; `writeData` ← result.
- Result selection:
  - `in_mem_to_reg`=0 → `in_alu_result`.
  - `in_mem_to_reg`=1 → aligned load data (see Configuration).
- Register 0 is never written: `WB` stays 0 for destination 0.
- Bypass, evaluated at each rising edge using pre-edge `WB`/`writeReg`/`writeData`:
  - `fwdN_sel` ← `WB & (writeReg == readRegN) & (readRegN != 0)`.
  - `fwdN_data` ← `writeData` on match, else holds.
- Both ports compare independently; both may select together.

## Timing
- Reset (async, immediate): `WB`=0, `writeReg`=0, `writeData`=0, `fwd1_sel`=`fwd2_sel`=0, `fwd1_data`=`fwd2_data`=0.
- Latency: MEM inputs at edge N → `WB`/`writeData` valid after edge N → register file written at edge N+1.
- `fwdN_sel`/`fwdN_data` change on the same edge as `RegDataN`; the consumer muxes combinationally.
- Write at edge N+1 is visible through the normal read path from edge N+2.
- Simultaneous `stall` and `flush`: flush wins.
- Stall does not repeat a write: the held instruction committed once.
- Reset mid-write: the pending write is dropped.
- Outputs have no combinational path from inputs.

## Configuration
- `MEMWB_BYTE_LOAD_EN` defined:
  - byte uses `in_alu_result[1:0]` lane (lane 0 = bits 7:0, little-endian); half uses `in_alu_result[1]` lane.
  - Sign- or zero-extended per `in_load_unsigned`.
- Not defined: load data = `in_mem_data` unchanged; `in_load_size` and `in_load_unsigned` ignored.

## Structure
- Shared package `mips_pkg`:
  - load-size encodings `LS_WORD`, `LS_BYTE`, `LS_HALF`
  - `REG_ZERO` constant
  - `DATA_W`/`REG_AW` defaults
- One sub-module, `load_align`: combinational lane select and extension, instantiated only under `MEMWB_BYTE_LOAD_EN`.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle → all outputs 0 immediately; no write occurs.
- ALU writeback: valid, reg_write, mem_to_reg=0, dest 8, ALU 0x0000_1234 → next cycle `WB`=1, `writeReg`=8, `writeData`=0x1234; dest 0 → `WB`=0.
- Same-edge bypass: write r9=0xDEAD_BEEF pending, `readReg1`=9, `readReg2`=10 at the write edge → `fwd1_sel`=1, `fwd1_data`=0xDEADBEEF, `fwd2_sel`=0; next cycle read r9 → `fwd1_sel`=0, register file returns 0xDEADBEEF.
- Stall/flush: stall one cycle → `WB`=0, `writeReg`/`writeData` held; stall+flush together → `WB`=0; a valid instruction the following cycle writes normally.
- Byte load (macro on): mem 0x80FF_7F01, addr offset 2, byte signed → 0xFFFF_FFFF; offset 3 unsigned → 0x0000_0080; half offset 2 signed → 0xFFFF_80FF.
- Macro off: same byte-load stimulus → `writeData`=0x80FF_7F01.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
//   - load-size encodings (LS_WORD / LS_BYTE / LS_HALF, 2'b11 reserved = word)
//   - REG_ZERO: architectural zero register, never written
//   - default datapath / register-address widths
package mips_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int REG_AW_DEFAULT = 5;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    LS_WORD = 2'b00,
    LS_BYTE = 2'b01,
    LS_HALF = 2'b10,
    LS_RSVD = 2'b11   // decoded as a word load
  } load_size_e;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: combinational sub-word load alignment.
// Selects the addressed byte / halfword from a raw memory word
// (little-endian, lane 0 = bits 7:0) and sign- or zero-extends it.
// Ports:
//   data_in      raw data-memory word
//   addr_lo      low two bits of the load address
//   size         load-size encoding (mips_pkg::load_size_e)
//   is_unsigned  zero-extend instead of sign-extend
//   data_out     aligned, extended load data
// Only the low 32 bits carry byte/half lanes; DATA_W must be >= 32.
module load_align
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data_out
);

  localparam int NUM_BYTES = 4;

  logic [NUM_BYTES-1:0][7:0]     lane;
  logic [NUM_BYTES/2-1:0][15:0]  half;
  logic [7:0]                    sel_byte;
  logic [15:0]                   sel_half;

  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
    assign lane[g] = data_in[8*g +: 8];
  end

  for (genvar g = 0; g < NUM_BYTES/2; g++) begin : g_half
    assign half[g] = data_in[16*g +: 16];
  end

  assign sel_byte = lane[addr_lo];
  assign sel_half = half[addr_lo[1]];

  always_comb begin
    data_out = data_in;
    case (size)
      LS_BYTE: data_out = {{(DATA_W-8){sel_byte[7] & ~is_unsigned}}, sel_byte};
      LS_HALF: data_out = {{(DATA_W-16){sel_half[15] & ~is_unsigned}}, sel_half};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register of the MIPS datapath.
// Captures memory-stage results, picks load data or ALU result, and drives
// the register file write port. Because the register file reads
// synchronously (same-edge read returns the stale value), a one-entry
// write-through bypass is registered alongside RegData1/RegData2.
// Optional feature: define MEMWB_BYTE_LOAD_EN to enable byte/half load
// alignment; otherwise load data is the raw memory word.
// Ports:
//   clk, rst_n            clock (rising), async active-low reset
//   stall, flush          hold / kill stage (flush wins); both insert bubble
//   in_*                  MEM-stage instruction fields
//   readReg1, readReg2    register-file read addresses this cycle
//   WB, writeReg, writeData  register-file write port
//   fwdN_sel, fwdN_data   bypass select/data, aligned with RegDataN
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [REG_AW-1:0] in_write_reg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  input  logic [REG_AW-1:0] readReg1,
  input  logic [REG_AW-1:0] readReg2,
  output logic              WB,
  output logic [REG_AW-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              fwd1_sel,
  output logic              fwd2_sel,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data
);

  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(REG_ZERO);

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] result;
  logic              wb_next;
  logic              hit1, hit2;

`ifdef MEMWB_BYTE_LOAD_EN
  load_align #(.DATA_W(DATA_W)) u_load_align (
    .data_in     (in_mem_data),
    .addr_lo     (in_alu_result[1:0]),
    .size        (in_load_size),
    .is_unsigned (in_load_unsigned),
    .data_out    (load_data)
  );
`else
  // Sub-word controls have no effect without alignment hardware.
  logic unused_load_cfg;
  assign unused_load_cfg = ^{in_load_size, in_load_unsigned};
  assign load_data       = in_mem_data;
`endif

  assign result  = in_mem_to_reg ? load_data : in_alu_result;
  assign wb_next = in_valid & in_reg_write & (in_write_reg != ZERO_REG);

  // Stage register. Stall and flush both bubble WB so a held instruction
  // commits exactly once; data fields simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB        <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else if (flush || stall) begin
      WB <= 1'b0;
    end else begin
      WB        <= wb_next;
      writeReg  <= in_write_reg;
      writeData <= result;
    end
  end

  // Bypass: the write currently on the port lands at this edge, while the
  // register file samples the pre-write contents for readRegN. Registering
  // the match here lines fwdN up with RegDataN one edge later.
  assign hit1 = WB & (writeReg == readReg1) & (readReg1 != ZERO_REG);
  assign hit2 = WB & (writeReg == readReg2) & (readReg2 != ZERO_REG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd1_sel  <= 1'b0;
      fwd2_sel  <= 1'b0;
      fwd1_data <= '0;
      fwd2_data <= '0;
    end else begin
      fwd1_sel <= hit1;
      fwd2_sel <= hit2;
      if (hit1) fwd1_data <= writeData;
      if (hit2) fwd2_data <= writeData;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage, with a small synchronous-
// read register file model downstream to exercise the bypass end to end.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        in_valid, in_reg_write, in_mem_to_reg;
  logic [4:0]  in_write_reg;
  logic [31:0] in_alu_result, in_mem_data;
  logic [1:0]  in_load_size;
  logic        in_load_unsigned;
  logic [4:0]  readReg1, readReg2;
  logic        WB;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        fwd1_sel, fwd2_sel;
  logic [31:0] fwd1_data, fwd2_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_write_reg(in_write_reg),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .readReg1(readReg1), .readReg2(readReg2),
    .WB(WB), .writeReg(writeReg), .writeData(writeData),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  // Register file model: synchronous read of pre-edge contents.
  logic [31:0] rf [32] = '{default: 32'h0};
  logic [31:0] rd1 = 32'h0, rd2 = 32'h0;
  always @(posedge clk) begin
    rd1 <= rf[readReg1];
    rd2 <= rf[readReg2];
    if (WB) rf[writeReg] <= writeData;
  end

  wire [31:0] use1 = fwd1_sel ? fwd1_data : rd1;
  wire [31:0] use2 = fwd2_sel ? fwd2_data : rd2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_op(input logic [4:0] dst, input logic m2r, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [1:0] sz, input logic uns);
    in_valid = 1'b1; in_reg_write = 1'b1; in_mem_to_reg = m2r;
    in_write_reg = dst; in_alu_result = alu; in_mem_data = mem;
    in_load_size = sz; in_load_unsigned = uns;
  endtask

  logic [31:0] exp_b2s, exp_b3u, exp_h2s, exp_b0u;

  initial begin
`ifdef MEMWB_BYTE_LOAD_EN
    exp_b2s = 32'hFFFF_FFFF; exp_b3u = 32'h0000_0080;
    exp_h2s = 32'hFFFF_80FF; exp_b0u = 32'h0000_0001;
`else
    exp_b2s = 32'h80FF_7F01; exp_b3u = 32'h80FF_7F01;
    exp_h2s = 32'h80FF_7F01; exp_b0u = 32'h80FF_7F01;
`endif
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0;
    in_write_reg = '0; in_alu_result = '0; in_mem_data = '0;
    in_load_size = 2'b00; in_load_unsigned = 1'b0;
    readReg1 = '0; readReg2 = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_wb", 32'(WB), 32'h0);
    check("rst_wreg", 32'(writeReg), 32'h0);
    check("rst_wdata", writeData, 32'h0);
    check("rst_fsel", {30'h0, fwd2_sel, fwd1_sel}, 32'h0);
    check("rst_fd1", fwd1_data, 32'h0);
    check("rst_fd2", fwd2_data, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // ALU writeback
    mem_op(5'd8, 1'b0, 32'h0000_1234, 32'hCAFE_0000, 2'b00, 1'b0);
    tick();
    check("alu_wb", 32'(WB), 32'h1);
    check("alu_wreg", 32'(writeReg), 32'd8);
    check("alu_wdata", writeData, 32'h0000_1234);
    mem_op(5'd0, 1'b0, 32'h0000_0055, 32'h0, 2'b00, 1'b0);
    tick();
    check("r0_wb", 32'(WB), 32'h0);
    check("rf_r8", rf[8], 32'h0000_1234);
    in_valid = 1'b0;
    mem_op(5'd7, 1'b0, 32'h0000_0077, 32'h0, 2'b00, 1'b0);
    in_valid = 1'b0;
    tick();
    check("invalid_wb", 32'(WB), 32'h0);

    // Same-edge bypass
    mem_op(5'd9, 1'b0, 32'hDEAD_BEEF, 32'h0, 2'b00, 1'b0);
    tick();
    check("byp_wb", 32'(WB), 32'h1);
    in_valid = 1'b0; readReg1 = 5'd9; readReg2 = 5'd10;
    tick();
    check("byp_f1sel", 32'(fwd1_sel), 32'h1);
    check("byp_f1data", fwd1_data, 32'hDEAD_BEEF);
    check("byp_f2sel", 32'(fwd2_sel), 32'h0);
    check("byp_rd1_stale", rd1, 32'h0);
    check("byp_use1", use1, 32'hDEAD_BEEF);
    tick();
    check("post_f1sel", 32'(fwd1_sel), 32'h0);
    check("post_rd1", rd1, 32'hDEAD_BEEF);
    check("post_f1hold", fwd1_data, 32'hDEAD_BEEF);

    // Both ports hit together
    mem_op(5'd11, 1'b0, 32'h0000_A5A5, 32'h0, 2'b00, 1'b0);
    readReg1 = 5'd0; readReg2 = 5'd0;
    tick();
    in_valid = 1'b0; readReg1 = 5'd11; readReg2 = 5'd11;
    tick();
    check("both_sel", {30'h0, fwd2_sel, fwd1_sel}, 32'h3);
    check("both_use2", use2, 32'h0000_A5A5);
    readReg1 = 5'd0; readReg2 = 5'd0;

    // Stall / flush
    mem_op(5'd12, 1'b0, 32'h0000_0C0C, 32'h0, 2'b00, 1'b0);
    tick();
    check("stl_pre_wb", 32'(WB), 32'h1);
    mem_op(5'd13, 1'b0, 32'h0000_0D0D, 32'h0, 2'b00, 1'b0);
    stall = 1'b1;
    tick();
    check("stl_wb", 32'(WB), 32'h0);
    check("stl_wreg", 32'(writeReg), 32'd12);
    check("stl_wdata", writeData, 32'h0000_0C0C);
    flush = 1'b1;
    tick();
    check("stlfl_wb", 32'(WB), 32'h0);
    stall = 1'b0; flush = 1'b0;
    tick();
    check("after_wb", 32'(WB), 32'h1);
    check("after_wreg", 32'(writeReg), 32'd13);
    check("after_wdata", writeData, 32'h0000_0D0D);
    check("rf_r12", rf[12], 32'h0000_0C0C);
    mem_op(5'd14, 1'b0, 32'h0000_0E0E, 32'h0, 2'b00, 1'b0);
    flush = 1'b1;
    tick();
    check("flush_wb", 32'(WB), 32'h0);
    flush = 1'b0;

    // Loads
    mem_op(5'd15, 1'b1, 32'h0000_1002, 32'h80FF_7F01, 2'b01, 1'b0);
    tick();
    check("ld_b2s", writeData, exp_b2s);
    mem_op(5'd15, 1'b1, 32'h0000_1003, 32'h80FF_7F01, 2'b01, 1'b1);
    tick();
    check("ld_b3u", writeData, exp_b3u);
    mem_op(5'd15, 1'b1, 32'h0000_1002, 32'h80FF_7F01, 2'b10, 1'b0);
    tick();
    check("ld_h2s", writeData, exp_h2s);
    mem_op(5'd15, 1'b1, 32'h0000_1000, 32'h80FF_7F01, 2'b01, 1'b1);
    tick();
    check("ld_b0u", writeData, exp_b0u);
    mem_op(5'd15, 1'b1, 32'h0000_1002, 32'h80FF_7F01, 2'b00, 1'b0);
    tick();
    check("ld_word", writeData, 32'h80FF_7F01);

    // Reset mid-write drops the pending write
    mem_op(5'd16, 1'b0, 32'h0000_1616, 32'h0, 2'b00, 1'b0);
    tick();
    check("mid_pre_wb", 32'(WB), 32'h1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_wb", 32'(WB), 32'h0);
    check("mid_wdata", writeData, 32'h0);
    check("mid_fd1", fwd1_data, 32'h0);
    tick();
    check("mid_rf16", rf[16], 32'h0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
